// File: rtl/kmeans_pkg.sv
// Shared widths, defaults and FSM state type for the k-means mean-phase divider scheduler.
package kmeans_pkg;
   localparam int SUM_W       = 20;
   localparam int CNT_W       = 12;
   localparam int N_REQ_DEF   = 4;
   localparam int DIV_LAT_DEF = 24;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } state_t;
endpackage

// File: rtl/mean_div_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from ptr; ptr advances past the served index.
// No backpressure of its own; ptr only moves when the owner reports completion via upd.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             upd,
   input  logic [IDX_W-1:0] upd_idx,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_vld
);
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] pos;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (upd) begin
         ptr <= (upd_idx == IDX_W'(N_REQ - 1)) ? '0 : upd_idx + 1'b1;
      end
   end

   // First requester at or after ptr wins, so every held request is reached within N_REQ grants.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      pos       = '0;
      for (int k = 0; k < N_REQ; k++) begin
         pos = IDX_W'((int'(ptr) + k) % N_REQ);
         if (!grant_vld && req[pos]) begin
            grant_vld  = 1'b1;
            grant_idx  = pos;
            grant[pos] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/mean_div_scheduler.sv
// Shares one pipelined divider among N_REQ cluster-mean requesters; ack at DIV_LAT+2 cycles after grant (1 if cnt=0).
// Requests are levels held until ack; en low blocks grants and aborts an in-flight divide without ack.
module mean_div_scheduler
   import kmeans_pkg::*;
#(
   parameter int N_REQ   = N_REQ_DEF,
   parameter int DIV_LAT = DIV_LAT_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*SUM_W-1:0] sum,
   input  logic [N_REQ*CNT_W-1:0] cnt,
   output logic [N_REQ-1:0]       ack,
   output logic [SUM_W-1:0]       mean,
   output logic                   zero_div,
   output logic                   busy,
   output logic                   div_ce,
   output logic                   div_sclr,
   output logic [SUM_W-1:0]       div_dividend,
   output logic [CNT_W-1:0]       div_divisor,
   input  logic [SUM_W-1:0]       div_quotient
);
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CTR_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

   state_t             state;
   state_t             nstate;
   logic [N_REQ-1:0]   grant;
   logic [IDX_W-1:0]   grant_idx;
   logic               grant_vld;
   logic [IDX_W-1:0]   idx;
   logic [SUM_W-1:0]   lat_sum;
   logic [CNT_W-1:0]   lat_cnt;
   logic [SUM_W-1:0]   sel_sum;
   logic [CNT_W-1:0]   sel_cnt;
   logic [CTR_W-1:0]   ctr;
   logic [SUM_W-1:0]   mean_q;
   logic               zero_q;
   logic               take;
   logic               ctr_last;
   logic               wait_run;

   rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .upd       (state == ST_RESP),
      .upd_idx   (idx),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_vld (grant_vld)
   );

   assign take     = (state == ST_IDLE) && en && grant_vld;
   assign ctr_last = (ctr == CTR_W'(DIV_LAT - 1));
   assign wait_run = (state == ST_WAIT) && en;

   always_comb begin
      sel_sum = '0;
      sel_cnt = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            sel_sum = sum[i*SUM_W +: SUM_W];
            sel_cnt = cnt[i*CNT_W +: CNT_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= nstate;
      end
   end

   // Completion is purely counter-based; div_quotient is never inspected for a done indication.
   always_comb begin
      nstate = state;
      case (state)
         ST_IDLE: if (take) nstate = (sel_cnt == '0) ? ST_RESP : ST_LOAD;
         ST_LOAD: nstate = en ? ST_WAIT : ST_IDLE;
         ST_WAIT: begin
            if (!en)           nstate = ST_IDLE;
            else if (ctr_last) nstate = ST_RESP;
         end
         ST_RESP: nstate = ST_IDLE;
         default: nstate = ST_IDLE;
      endcase
   end

   always_comb begin
      busy         = (state != ST_IDLE);
      div_sclr     = (state == ST_LOAD);
      div_ce       = wait_run;
      div_dividend = '0;
      div_divisor  = '0;
      if (state == ST_LOAD || state == ST_WAIT) begin
         div_dividend = lat_sum;
         div_divisor  = lat_cnt;
      end
      ack = '0;
      for (int i = 0; i < N_REQ; i++) begin
         ack[i] = (state == ST_RESP) && (idx == IDX_W'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx     <= '0;
         lat_sum <= '0;
         lat_cnt <= '0;
         ctr     <= '0;
         mean_q  <= '0;
         zero_q  <= 1'b0;
      end else begin
         if (take) begin
            idx     <= grant_idx;
            lat_sum <= sel_sum;
            lat_cnt <= sel_cnt;
            if (sel_cnt == '0) begin
               mean_q <= '0;
               zero_q <= 1'b1;
            end
         end
         if (wait_run && !ctr_last) begin
            ctr <= ctr + 1'b1;
         end else begin
            ctr <= '0;
         end
         if (wait_run && ctr_last) begin
            mean_q <= div_quotient;
            zero_q <= 1'b0;
         end
      end
   end

   assign mean     = mean_q;
   assign zero_div = zero_q;
endmodule

// File: tb/tb_mean_div_scheduler.sv
// Bench for mean_div_scheduler: behavioural divider plus a round-robin / arithmetic reference model.
module tb_mean_div_scheduler;
   localparam int LAT = 24;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [3:0]  req = '0;
   logic [79:0] sum = '0;
   logic [47:0] cnt = '0;
   logic [3:0]  ack;
   logic [19:0] mean;
   logic        zero_div;
   logic        busy;
   logic        div_ce;
   logic        div_sclr;
   logic [19:0] div_dividend;
   logic [11:0] div_divisor;
   logic [19:0] div_quotient;

   int checks = 0;
   int errors = 0;
   int model_ptr = 0;
   int ce_cnt = 0;

   mean_div_scheduler #(.N_REQ(4), .DIV_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req), .sum(sum), .cnt(cnt),
      .ack(ack), .mean(mean), .zero_div(zero_div), .busy(busy),
      .div_ce(div_ce), .div_sclr(div_sclr), .div_dividend(div_dividend),
      .div_divisor(div_divisor), .div_quotient(div_quotient)
   );

   always #5 clk = ~clk;

   // Divider model: quotient is only correct once LAT ce-enabled cycles have elapsed since sclr.
   always @(posedge clk) begin
      if (div_sclr) ce_cnt <= 0;
      else if (div_ce) ce_cnt <= ce_cnt + 1;
   end
   always_comb begin
      div_quotient = 20'hBAD5A;
      if (ce_cnt >= LAT - 1 && div_divisor != 0) div_quotient = div_dividend / {8'd0, div_divisor};
   end

   function automatic int rr_pick(input logic [3:0] r, input int p);
      logic [3:0] t;
      for (int k = 0; k < 4; k++) begin
         t = r >> ((p + k) % 4);
         if (t[0]) return (p + k) % 4;
      end
      return -1;
   endfunction

   function automatic logic [19:0] exp_mean(input logic [19:0] s, input logic [11:0] c);
      if (c == 0) return 20'd0;
      return s / {8'd0, c};
   endfunction

   task automatic wait_ack(output logic [3:0] a, output logic [19:0] m, output logic z,
                           output int cyc, output logic ce_seen);
      a = '0; m = '0; z = 1'b0; cyc = 0; ce_seen = 1'b0;
      while (a == 0 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (div_ce) ce_seen = 1'b1;
         a = ack; m = mean; z = zero_div;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; req = '0;
      repeat (2) @(negedge clk);
      checks++; if (ack !== 4'b0) begin errors++; $display("FAIL reset_ack got %0h want 0", ack); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
      checks++; if ({div_ce, div_sclr} !== 2'b00) begin errors++; $display("FAIL reset_div_ctl got %0b want 0", {div_ce, div_sclr}); end
      checks++; if ({mean, zero_div, div_dividend, div_divisor} !== 53'd0) begin errors++; $display("FAIL reset_data got %0h want 0", {mean, zero_div, div_dividend, div_divisor}); end
      rst_n = 1'b1; en = 1'b1; model_ptr = 0;
   endtask

   task automatic test_all_four();
      logic [3:0] a; logic [19:0] m; logic z; int cyc; logic ce; int e;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         sum[i*20 +: 20] = 20'((i + 1) * 100);
         cnt[i*12 +: 12] = 12'((i + 1) * 10);
      end
      req = 4'b1111;
      for (int n = 0; n < 4; n++) begin
         e = rr_pick(req, model_ptr);
         wait_ack(a, m, z, cyc, ce);
         checks++; if (a !== (4'b1 << e) || e !== n) begin errors++; $display("FAIL all4_order got %0h want %0h", a, 4'b1 << n); end
         checks++; if (m !== 20'd10 || z !== 1'b0) begin errors++; $display("FAIL all4_mean got %0d/%0b want 10/0", m, z); end
         checks++; if (cyc !== (n == 0 ? 26 : 27)) begin errors++; $display("FAIL all4_lat got %0d want %0d", cyc, n == 0 ? 26 : 27); end
         req[e] = 1'b0;
         model_ptr = (e + 1) % 4;
      end
   endtask

   task automatic test_single();
      logic [3:0] a; logic [19:0] m; logic z; int cyc; logic ce;
      @(negedge clk);
      sum[19:0] = 20'd1000; cnt[11:0] = 12'd8; req = 4'b0001;
      wait_ack(a, m, z, cyc, ce);
      req = '0; model_ptr = 1;
      checks++; if (a !== 4'b0001) begin errors++; $display("FAIL single_ack got %0h want 1", a); end
      checks++; if (cyc !== 26) begin errors++; $display("FAIL single_lat got %0d want 26", cyc); end
      checks++; if (m !== 20'd125 || z !== 1'b0) begin errors++; $display("FAIL single_mean got %0d/%0b want 125/0", m, z); end
      @(negedge clk);
      checks++; if (ack !== 4'b0 || mean !== 20'd125) begin errors++; $display("FAIL single_hold got %0h/%0d want 0/125", ack, mean); end
   endtask

   task automatic test_zero_div();
      logic [3:0] a; logic [19:0] m; logic z; int cyc; logic ce;
      @(negedge clk);
      sum[40 +: 20] = 20'd555; cnt[24 +: 12] = 12'd0; req = 4'b0100;
      wait_ack(a, m, z, cyc, ce);
      req = '0; model_ptr = 3;
      checks++; if (a !== 4'b0100 || cyc !== 1) begin errors++; $display("FAIL zero_ack got %0h@%0d want 4@1", a, cyc); end
      checks++; if (m !== 20'd0 || z !== 1'b1) begin errors++; $display("FAIL zero_mean got %0d/%0b want 0/1", m, z); end
      checks++; if (ce !== 1'b0) begin errors++; $display("FAIL zero_ce got %0b want 0", ce); end
   endtask

   task automatic test_abort();
      logic [3:0] a; logic [19:0] m; logic z; int cyc; logic ce; logic seen;
      @(negedge clk);
      sum[20 +: 20] = 20'd5000; cnt[12 +: 12] = 12'd7; req = 4'b0010; seen = 1'b0;
      repeat (12) begin @(negedge clk); if (ack != 0) seen = 1'b1; end
      en = 1'b0;
      #1;
      checks++; if (div_ce !== 1'b0) begin errors++; $display("FAIL abort_ce got %0b want 0", div_ce); end
      repeat (2) begin @(negedge clk); if (ack != 0) seen = 1'b1; end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b want 0", busy); end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_noack got %0b want 0", seen); end
      sum[40 +: 20] = 20'd900; cnt[24 +: 12] = 12'd3; req = 4'b0110; en = 1'b1;
      wait_ack(a, m, z, cyc, ce);
      req[1] = 1'b0;
      checks++; if (a !== 4'b0010 || cyc !== 26) begin errors++; $display("FAIL abort_regrant got %0h@%0d want 2@26", a, cyc); end
      checks++; if (m !== 20'd714) begin errors++; $display("FAIL abort_mean got %0d want 714", m); end
      wait_ack(a, m, z, cyc, ce);
      req = '0; model_ptr = 3;
      checks++; if (a !== 4'b0100 || m !== 20'd300) begin errors++; $display("FAIL abort_next got %0h/%0d want 4/300", a, m); end
   endtask

   task automatic test_wrap();
      logic [3:0] a; logic [19:0] m; logic z; int cyc; logic ce;
      @(negedge clk);
      sum[60 +: 20] = 20'd4000; cnt[36 +: 12] = 12'd40; req = 4'b1000;
      wait_ack(a, m, z, cyc, ce);
      req = '0;
      checks++; if (a !== 4'b1000 || m !== 20'd100) begin errors++; $display("FAIL wrap_first got %0h/%0d want 8/100", a, m); end
      @(negedge clk);
      sum[19:0] = 20'd77; cnt[11:0] = 12'd7; req = 4'b1001;
      wait_ack(a, m, z, cyc, ce);
      req[0] = 1'b0;
      checks++; if (a !== 4'b0001 || m !== 20'd11) begin errors++; $display("FAIL wrap_idx0 got %0h/%0d want 1/11", a, m); end
      wait_ack(a, m, z, cyc, ce);
      req = '0; model_ptr = 0;
      checks++; if (a !== 4'b1000 || cyc !== 27) begin errors++; $display("FAIL wrap_idx3 got %0h@%0d want 8@27", a, cyc); end
   endtask

   task automatic test_reset_mid();
      logic [3:0] a; logic [19:0] m; logic z; int cyc; logic ce;
      @(negedge clk);
      sum[40 +: 20] = 20'd800; cnt[24 +: 12] = 12'd4; req = 4'b0100;
      wait_ack(a, m, z, cyc, ce);
      req = '0;
      checks++; if (a !== 4'b0100 || m !== 20'd200) begin errors++; $display("FAIL rst_pre got %0h/%0d want 4/200", a, m); end
      @(negedge clk);
      sum[60 +: 20] = 20'd999; cnt[36 +: 12] = 12'd9; req = 4'b1000;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if ({ack, busy, div_ce, div_sclr} !== 7'd0) begin errors++; $display("FAIL rst_ctl got %0h want 0", {ack, busy, div_ce, div_sclr}); end
      checks++; if ({mean, zero_div, div_dividend, div_divisor} !== 53'd0) begin errors++; $display("FAIL rst_data got %0h want 0", {mean, zero_div, div_dividend, div_divisor}); end
      repeat (2) @(negedge clk);
      sum[20 +: 20] = 20'd60; cnt[12 +: 12] = 12'd6; req = 4'b1010;
      rst_n = 1'b1;
      wait_ack(a, m, z, cyc, ce);
      req = '0; model_ptr = 2;
      checks++; if (a !== 4'b0010 || cyc !== 26 || m !== 20'd10) begin errors++; $display("FAIL rst_after got %0h@%0d/%0d want 2@26/10", a, cyc, m); end
   endtask

   task automatic test_random();
      logic [3:0] a; logic [19:0] m; logic z; int cyc; logic ce; int e; int want_lat;
      logic [19:0] rs [4];
      logic [11:0] rc [4];
      for (int r = 0; r < 20; r++) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            rs[i] = 20'($urandom);
            rc[i] = ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
            sum[i*20 +: 20] = rs[i];
            cnt[i*12 +: 12] = rc[i];
         end
         req = 4'($urandom_range(1, 15));
         for (int n = 0; n < 4 && req != 0; n++) begin
            e = rr_pick(req, model_ptr);
            want_lat = (rc[e] == 0 ? 1 : LAT + 2) + (n == 0 ? 0 : 1);
            wait_ack(a, m, z, cyc, ce);
            checks++;
            if (a !== (4'b1 << e) || cyc !== want_lat || m !== exp_mean(rs[e], rc[e]) || z !== (rc[e] == 0)) begin
               errors++;
               $display("FAIL rand_op got ack %0h lat %0d mean %0h zd %0b want ack %0h lat %0d mean %0h zd %0b",
                        a, cyc, m, z, 4'b1 << e, want_lat, exp_mean(rs[e], rc[e]), rc[e] == 0);
            end
            req[e] = 1'b0;
            model_ptr = (e + 1) % 4;
         end
         req = '0;
      end
   endtask

   initial begin
      test_reset();
      test_all_four();
      test_single();
      test_zero_div();
      test_abort();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mean_div_scheduler.md
MEAN_DIV_SCHEDULER -- requirements
Module: mean_div_scheduler

Interface
REQ-001 Parameter N_REQ, 4, number of cluster-mean requesters sharing one divider.
REQ-002 Parameter DIV_LAT, 24, divider latency in ce-enabled cycles from operands stable to quotient valid.
REQ-003 Port clk  in  1  sole clock; all state on rising edge.
REQ-004 Port rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port en  in  1  algorithm mean-phase enable; low = no new grants, abort in-flight divide.
REQ-006 Port req  in  N_REQ  per-cluster request level; held until matching ack.
REQ-007 Port sum  in  N_REQ*20  packed dividends; slice i belongs to req[i].
REQ-008 Port cnt  in  N_REQ*12  packed divisors (member counts); slice i belongs to req[i].
REQ-009 Port ack  out  N_REQ  one-cycle one-hot completion pulse.
REQ-010 Port mean  out  20  quotient; valid only while ack is non-zero.
REQ-011 Port zero_div  out  1  high with ack when the granted cnt was 0.
REQ-012 Port busy  out  1  high whenever FSM is not IDLE.
REQ-013 Ports div_ce out 1, div_sclr out 1, div_dividend out 20, div_divisor out 12, div_quotient in 20: shared divider connection.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, WAIT, RESP.
REQ-015 IDLE: if en=1 and req!=0, grant round-robin starting at pointer ptr; latch index, sum slice, cnt slice.
REQ-016 IDLE grant with latched cnt=0 SHALL go to RESP with mean=0, zero_div=1, divider untouched.
REQ-017 IDLE grant with cnt!=0 SHALL go to LOAD; LOAD drives div_sclr=1 for exactly one cycle, div_ce=0.
REQ-018 WAIT SHALL drive div_ce=1 for exactly DIV_LAT cycles, counted by an internal counter from 0 to DIV_LAT-1.
REQ-019 On the final WAIT cycle, div_quotient SHALL be registered into mean; next state RESP.
REQ-020 div_dividend/div_divisor SHALL hold latched operands, stable from LOAD through end of WAIT; 0 in IDLE.
REQ-021 RESP: ack[idx]=1 for one cycle, ptr <= (idx+1) mod N_REQ, next state IDLE; no grant in RESP.
REQ-022 Latency: grant edge T0 -> ack high in cycle T0+DIV_LAT+2 (cnt!=0), T0+1 (cnt=0).
REQ-023 Controller SHALL NOT infer completion from div_quotient value; completion is counter-based only.
REQ-024 en falling in LOAD/WAIT SHALL abort: div_ce=0, FSM to IDLE next cycle, no ack, ptr unchanged.
REQ-025 req[idx] dropping mid-operation SHALL be ignored; operation completes and ack still pulses.
REQ-026 Requester SHALL drop req within the cycle after ack; a req still high in IDLE is a new request.
REQ-027 mean and zero_div SHALL hold their last values outside RESP; consumers qualify with ack.
REQ-028 Arbiter SHALL be starvation-free: any held req is granted within N_REQ grants.

Reset
REQ-029 rst_n low SHALL force IDLE, ptr=0, counter=0, ack=0, mean=0, zero_div=0, busy=0, div_ce=0, div_sclr=0, div operands=0.
REQ-030 Reset assertion mid-WAIT SHALL discard the operation with no ack; first grant after release follows ptr=0.

Structure
REQ-031 Package kmeans_pkg SHALL hold SUM_W=20, CNT_W=12, the FSM state type, and default N_REQ/DIV_LAT.
REQ-032 One sub-module rr_arbiter SHALL hold the round-robin pointer and one-hot grant logic; FSM, counter and divider drive stay in mean_div_scheduler.

Verification
REQ-033 Bench with behavioural divider model, DIV_LAT=24: req=0001, sum[0]=1000, cnt[0]=8 -> ack=0001 at T0+26, mean=125, zero_div=0.
REQ-034 req=1111, all held, sums 100/200/300/400, cnts 10/20/30/40 -> acks in order 0,1,2,3, each mean=10.
REQ-035 req=0100, cnt[2]=0, sum[2]=555 -> ack=0100 at T0+1, mean=0, zero_div=1, div_ce never high.
REQ-036 Grant req[1], drop en at WAIT cycle 10 -> no ack, busy=0 two cycles later, ptr still selects req[1] first on re-enable.
REQ-037 rst_n low at WAIT cycle 5 -> all outputs 0 asynchronously; after release, req=1010 grants index 1 first.
REQ-038 Grant idx 3 then req=1001 -> next grant idx 0 (wrap-around), not idx 3.
